// File: rtl/downcounter6bit_reload.sv
// Synchronous down counter with parallel load, count enable and optional
// auto-reload from a latched reload value; tc/uf are registered one-cycle pulses.
module downcounter6bit_reload #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             uf
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             uf_q, uf_d;

  // Next-state decode: load beats enable; at zero, mode picks hold or reload.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    uf_d     = 1'b0;
    if (load) begin
      count_d  = din;
      reload_d = din;
    end else if (en) begin
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else if (count_q == CNT_ONE) begin
        count_d = CNT_ZERO;
        tc_d    = 1'b1;
      end else if (mode) begin
        count_d = reload_q;
        uf_d    = 1'b1;
      end else begin
        count_d = CNT_ZERO;
      end
    end else begin
      count_d  = count_q;
      reload_d = reload_q;
    end
  end

  // State and pulse registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      uf_q     <= uf_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == CNT_ZERO);
  assign tc    = tc_q;
  assign uf    = uf_q;

endmodule

// File: doc/downcounter6bit_reload.md
# downcounter6bit_reload

Synchronous 6-bit down counter with parallel load, enable and optional auto-reload. It is the counting-down counterpart to the block's ripple up counter. It serves as a programmable interval timer and terminal-count generator next to the existing counters. All flops share one clock, so the outputs are glitch-free and sampled on a single edge, unlike a ripple chain.

## Interface
- WIDTH, 6, counter and reload width in bits (minimum 2)
- clk  in  1  clock; all state updates on the rising edge
- clr  in  1  asynchronous, active-low reset
- load  in  1  parallel-load strobe; copies din into both count and the reload register
- din  in  WIDTH  load value
- en  in  1  count enable; the counter decrements once per clk edge while high
- mode  in  1  wrap behaviour at zero: 0 = one-shot (hold at zero), 1 = auto-reload
- count  out  WIDTH  current counter value (registered)
- zero  out  1  high whenever count == 0 (decoded from the count register, no added latency)
- tc  out  1  terminal count: registered 1-cycle pulse on each counted 1 -> 0 transition
- uf  out  1  underflow/reload: registered 1-cycle pulse when auto-reload fires

## Operation
- Reset (clr low, asynchronous):
  - count = 0, reload register = 0
  - tc = 0, uf = 0, zero = 1
- Priority on each rising edge, clr high:
  1. load = 1:
     - count <= din, reload <= din
     - tc <= 0, uf <= 0
     - en is ignored this cycle
  2. en = 1 and count > 1:
     - count <= count - 1
     - tc <= 0, uf <= 0
  3. en = 1 and count == 1:
     - count <= 0
     - tc <= 1, uf <= 0
  4. en = 1 and count == 0, mode = 1:
     - count <= reload
     - uf <= 1, tc <= 0
  5. en = 1 and count == 0, mode = 0:
     - count holds at 0
     - tc <= 0, uf <= 0
  6. en = 0:
     - count and reload hold
     - tc <= 0, uf <= 0
- Arithmetic is modulo 2^WIDTH unsigned. count never wraps to all-ones; the transition 0 -> 2^WIDTH-1 is forbidden.
- Auto-reload period is reload + 1 enabled cycles: N down to 0, then back to N.
- reload = 0 in mode 1: count stays 0 and uf pulses on every enabled cycle. tc never fires.
- Loading 0 sets zero the next cycle; tc is not generated.
- mode is sampled every edge. Changing mode mid-count affects only the next zero-crossing decision.
- The reload register changes only on load or reset.

## Timing
- Load latency: count = din one edge after load is sampled high.
- Decrement latency: 1 edge per enabled cycle.
- tc and uf are asserted in the cycle following the edge that caused them. They are high for exactly one clk period unless the causing condition repeats on consecutive edges.
- zero is combinational from count, so it is valid in the same cycle count changes.
- clr takes effect immediately without a clock. Deassertion is synchronous to clk by the system; the first edge after deassertion applies the normal rules.
- load and en asserted together: load wins, no decrement occurs, and neither tc nor uf is generated.

## Test plan
- Reset check: clr low mid-count at count=23 -> count=0, zero=1, tc=0, uf=0 immediately, without waiting for an edge.
- One-shot: mode=0, load din=5, then en=1 for 8 cycles:
  - count goes 5,4,3,2,1,0,0,0
  - tc high for exactly the one cycle after count reaches 0
  - uf never asserts
- Auto-reload: mode=1, load din=3, en held high for 10 cycles:
  - count goes 3,2,1,0,3,2,1,0,3,2
  - tc pulses after each 1->0 step
  - uf pulses after each 0->3 step
- Load priority: during counting at count=9, assert load=1 with din=40 and en=1 -> next count=40, no decrement, tc=0, uf=0. Later reloads use 40.
- Enable gating and boundary: load din=63, toggle en 1/0 alternately -> count decrements only on en cycles. Reach 0 in mode=0, then switch to mode=1 with en=1 -> count=63 and uf pulses once.
- Zero reload: mode=1, load din=0, en=1 for 4 cycles -> count stays 0, zero=1, uf high all 4 cycles, tc=0.
